// File: rtl/agg_relu_4n.sv
`default_nettype none
// ============================================================================
//  Module   : agg_relu_4n
//  Purpose  : 4-node graph aggregation stage. Captures 16 signed MAC results
//             and an adjacency matrix, then for each destination node sums the
//             features of its adjacent source nodes, applies ReLU, an
//             arithmetic right shift and positive saturation, and emits one
//             node per valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module agg_relu_4n #(
    parameter int AGG_IN_SIZE  = 13,
    parameter int AGG_OUT_SIZE = 7,
    parameter int AGG_SHIFT    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mac_ready,
    input  logic signed [AGG_IN_SIZE-1:0]  in0_n0,
    input  logic signed [AGG_IN_SIZE-1:0]  in1_n0,
    input  logic signed [AGG_IN_SIZE-1:0]  in2_n0,
    input  logic signed [AGG_IN_SIZE-1:0]  in3_n0,
    input  logic signed [AGG_IN_SIZE-1:0]  in0_n1,
    input  logic signed [AGG_IN_SIZE-1:0]  in1_n1,
    input  logic signed [AGG_IN_SIZE-1:0]  in2_n1,
    input  logic signed [AGG_IN_SIZE-1:0]  in3_n1,
    input  logic signed [AGG_IN_SIZE-1:0]  in0_n2,
    input  logic signed [AGG_IN_SIZE-1:0]  in1_n2,
    input  logic signed [AGG_IN_SIZE-1:0]  in2_n2,
    input  logic signed [AGG_IN_SIZE-1:0]  in3_n2,
    input  logic signed [AGG_IN_SIZE-1:0]  in0_n3,
    input  logic signed [AGG_IN_SIZE-1:0]  in1_n3,
    input  logic signed [AGG_IN_SIZE-1:0]  in2_n3,
    input  logic signed [AGG_IN_SIZE-1:0]  in3_n3,
    input  logic [15:0]                    adj,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [1:0]                     out_node,
    output logic signed [AGG_OUT_SIZE-1:0] out0,
    output logic signed [AGG_OUT_SIZE-1:0] out1,
    output logic signed [AGG_OUT_SIZE-1:0] out2,
    output logic signed [AGG_OUT_SIZE-1:0] out3,
    output logic                           done,
    output logic                           overrun
);

    // Sum of up to four operands needs two extra bits to never overflow.
    localparam int c_SW = AGG_IN_SIZE + 2;
    localparam logic signed [c_SW-1:0] c_MAX = c_SW'((1 << (AGG_OUT_SIZE - 1)) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AGG  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] node_q, node_d;
    logic       out_valid_q, out_valid_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;
    logic       mac_ready_q;

    logic       w_capture;
    logic       w_latch;
    logic       w_load;

    // Inputs regrouped as [feature][source node].
    logic signed [AGG_IN_SIZE-1:0]  w_in   [4][4];
    logic signed [AGG_IN_SIZE-1:0]  data_q [4][4];
    logic [15:0]                    adj_q;
    logic signed [AGG_OUT_SIZE-1:0] w_feat [4];
    logic signed [AGG_OUT_SIZE-1:0] out_q  [4];
    logic [1:0]                     out_node_q;

    assign w_in[0][0] = in0_n0;
    assign w_in[1][0] = in1_n0;
    assign w_in[2][0] = in2_n0;
    assign w_in[3][0] = in3_n0;
    assign w_in[0][1] = in0_n1;
    assign w_in[1][1] = in1_n1;
    assign w_in[2][1] = in2_n1;
    assign w_in[3][1] = in3_n1;
    assign w_in[0][2] = in0_n2;
    assign w_in[1][2] = in1_n2;
    assign w_in[2][2] = in2_n2;
    assign w_in[3][2] = in3_n2;
    assign w_in[0][3] = in0_n3;
    assign w_in[1][3] = in1_n3;
    assign w_in[2][3] = in2_n3;
    assign w_in[3][3] = in3_n3;

    // Rising edge of the upstream ready level starts a frame.
    assign w_capture = mac_ready & ~mac_ready_q;

    // Control registers; mac_ready_q resets high so a level already present at
    // reset release is not mistaken for a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            node_q      <= 2'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            mac_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            node_q      <= node_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            mac_ready_q <= mac_ready;
        end
    end

    // Next-state logic; the done cycle counts as busy for capture purposes.
    always_comb begin
        state_d     = state_q;
        node_d      = node_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        w_latch     = 1'b0;
        w_load      = 1'b0;

        if (w_capture && !(state_q == IDLE && !done_q)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (w_capture && !done_q) begin
                    w_latch = 1'b1;
                    node_d  = 2'd0;
                    state_d = AGG;
                end
            end
            AGG: begin
                w_load      = 1'b1;
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (node_q == 2'd3) begin
                        done_d  = 1'b1;
                        node_d  = 2'd0;
                        state_d = IDLE;
                    end else begin
                        node_d  = node_q + 2'd1;
                        state_d = AGG;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame capture: features and adjacency are frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_q <= '0;
            for (int f = 0; f < 4; f++) begin
                for (int j = 0; j < 4; j++) begin
                    data_q[f][j] <= '0;
                end
            end
        end else if (w_latch) begin
            adj_q <= adj;
            for (int f = 0; f < 4; f++) begin
                for (int j = 0; j < 4; j++) begin
                    data_q[f][j] <= w_in[f][j];
                end
            end
        end
    end

    generate
        for (genvar f = 0; f < 4; f++) begin : g_feat
            logic signed [c_SW-1:0]         w_sum;
            logic signed [c_SW-1:0]         w_shift;
            logic signed [AGG_OUT_SIZE-1:0] w_res;

            // Masked neighbour sum, ReLU, shift and clamp for one feature.
            always_comb begin
                w_sum = '0;
                for (int j = 0; j < 4; j++) begin
                    if (adj_q[{node_q, 2'(j)}]) begin
                        w_sum = w_sum + {{2{data_q[f][j][AGG_IN_SIZE-1]}}, data_q[f][j]};
                    end
                end
                w_shift = w_sum >>> AGG_SHIFT;
                if (w_sum[c_SW-1]) begin
                    w_res = '0;
                end else if (w_shift > c_MAX) begin
                    w_res = c_MAX[AGG_OUT_SIZE-1:0];
                end else begin
                    w_res = w_shift[AGG_OUT_SIZE-1:0];
                end
            end

            assign w_feat[f] = w_res;
        end
    endgenerate

    // Result registers, loaded once per node and held through EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_node_q <= 2'd0;
            for (int f = 0; f < 4; f++) begin
                out_q[f] <= '0;
            end
        end else if (w_load) begin
            out_node_q <= node_q;
            for (int f = 0; f < 4; f++) begin
                out_q[f] <= w_feat[f];
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_node  = out_node_q;
    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_agg_relu_4n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_agg_relu_4n
//  Purpose  : Directed bench for agg_relu_4n with an expected-result queue
//             drained by an independent output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_agg_relu_4n;

    localparam int IW = 13;
    localparam int OW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 mac_ready;
    logic                 out_ready;
    logic [15:0]          adj;
    logic signed [IW-1:0] tin [4][4];   // [feature][source node]
    logic                 busy;
    logic                 out_valid;
    logic                 done;
    logic                 overrun;
    logic [1:0]           out_node;
    logic signed [OW-1:0] out0, out1, out2, out3;

    typedef struct packed {
        logic [1:0]    node;
        logic [OW-1:0] o0;
        logic [OW-1:0] o1;
        logic [OW-1:0] o2;
        logic [OW-1:0] o3;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   checks   = 0;
    int   failures = 0;
    int   vk, dk, found, ndone;

    agg_relu_4n #(
        .AGG_IN_SIZE (IW),
        .AGG_OUT_SIZE(OW),
        .AGG_SHIFT   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mac_ready(mac_ready),
        .in0_n0(tin[0][0]), .in1_n0(tin[1][0]), .in2_n0(tin[2][0]), .in3_n0(tin[3][0]),
        .in0_n1(tin[0][1]), .in1_n1(tin[1][1]), .in2_n1(tin[2][1]), .in3_n1(tin[3][1]),
        .in0_n2(tin[0][2]), .in1_n2(tin[1][2]), .in2_n2(tin[2][2]), .in3_n2(tin[3][2]),
        .in0_n3(tin[0][3]), .in1_n3(tin[1][3]), .in2_n3(tin[2][3]), .in3_n3(tin[3][3]),
        .adj      (adj),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_node (out_node),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .done     (done),
        .overrun  (overrun)
    );

    // Monitor: every handshake pops one expected node result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_a = {out_node, out0, out1, out2, out3};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL emit_unexpected: got node=%0d out=%0d,%0d,%0d,%0d with nothing expected",
                         out_node, out0, out1, out2, out3);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL emit_node%0d: got node=%0d out=%0d,%0d,%0d,%0d expected node=%0d out=%0d,%0d,%0d,%0d",
                             mon_e.node, mon_a.node, mon_a.o0, mon_a.o1, mon_a.o2, mon_a.o3,
                             mon_e.node, mon_e.o0, mon_e.o1, mon_e.o2, mon_e.o3);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int n, input int a, input int b, input int c, input int d);
        exp_t e;
        e.node = 2'(n);
        e.o0   = OW'(a);
        e.o1   = OW'(b);
        e.o2   = OW'(c);
        e.o3   = OW'(d);
        exp_q.push_back(e);
    endtask

    task automatic set_all(input int v);
        for (int f = 0; f < 4; f++)
            for (int j = 0; j < 4; j++)
                tin[f][j] = IW'(v);
    endtask

    // Reference data set: feature rows across source nodes 0..3.
    task automatic set_d1();
        tin[0][0] = 100;  tin[0][1] = 200;   tin[0][2] = -50; tin[0][3] = 10;
        tin[1][0] = 16;   tin[1][1] = 32;    tin[1][2] = 48;  tin[1][3] = 64;
        tin[2][0] = 1000; tin[2][1] = -2000; tin[2][2] = 500; tin[2][3] = 300;
        tin[3][0] = 0;    tin[3][1] = 0;     tin[3][2] = 0;   tin[3][3] = 0;
    endtask

    // Expected results of set_d1 with adj = 16'h8421 (node i sees only itself).
    task automatic push_d1_diag();
        push(0, 6, 1, 62, 0);
        push(1, 12, 2, 0, 0);
        push(2, 0, 3, 31, 0);
        push(3, 0, 4, 18, 0);
    endtask

    // Expected results of set_d1 with adj = 16'h000B.
    task automatic push_d1_b();
        push(0, 19, 7, 0, 0);
        push(1, 0, 0, 0, 0);
        push(2, 0, 0, 0, 0);
        push(3, 0, 0, 0, 0);
    endtask

    // Raise mac_ready; k=0 is the capture edge. Returns first out_valid and done cycles.
    task automatic run_frame(input bit hold, output int valid_k, output int done_k);
        valid_k   = -1;
        done_k    = -1;
        mac_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!hold) mac_ready = 1'b0;
            if (out_valid && valid_k < 0) valid_k = k;
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic wait_done(output int done_k);
        done_k = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        mac_ready = 1'b1;
        out_ready = 1'b1;
        adj       = 16'h0000;
        set_all(0);

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_out_node", out_node, 0);
        chk("rst_outs", {out0, out1, out2, out3}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // mac_ready already high at release must not start a frame.
        repeat (5) tick();
        chk("release_level_no_capture", busy, 0);
        mac_ready = 1'b0;
        tick(); tick();

        // Basic flow and latency.
        set_d1();
        adj = 16'h000B;
        push_d1_b();
        run_frame(1'b0, vk, dk);
        chk("basic_valid_latency", vk, 1);
        chk("basic_done_latency", dk, 8);
        tick();
        chk("basic_done_one_cycle", done, 0);
        tick();

        // Positive saturation.
        set_all(4095);
        adj = 16'hFFFF;
        for (int n = 0; n < 4; n++) push(n, 63, 63, 63, 63);
        run_frame(1'b0, vk, dk);
        chk("sat_done_latency", dk, 8);
        tick(); tick();

        // ReLU clamps negative sums.
        set_all(-4096);
        for (int n = 0; n < 4; n++) push(n, 0, 0, 0, 0);
        run_frame(1'b0, vk, dk);
        chk("relu_done_latency", dk, 8);
        tick(); tick();

        // Backpressure on node 1.
        set_d1();
        adj = 16'h8421;
        push_d1_diag();
        mac_ready = 1'b1;
        tick();
        mac_ready = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid && out_node == 2'd1) begin
                found = 1;
                break;
            end
        end
        chk("bp_reach_node1", found, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold_c%0d", i), {out_valid, out_node, out0, out1, out2},
                {1'b1, 2'd1, 7'd12, 7'd2, 7'd0});
        end
        out_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid && out_node == 2'd2) begin
                found = 1;
                break;
            end
        end
        chk("bp_node2_follows", found, 1);
        wait_done(dk);
        chk("bp_done_reached", (dk >= 0), 1);
        tick(); tick();

        // mac_ready held high through the frame and after.
        set_d1();
        adj = 16'h8421;
        push_d1_diag();
        run_frame(1'b1, vk, dk);
        chk("level_done_latency", dk, 8);
        repeat (5) tick();
        chk("level_single_capture", busy, 0);
        chk("level_no_overrun", overrun, 0);
        mac_ready = 1'b0;
        tick(); tick();

        // Overrun: second rising edge during node 0 EMIT with different data.
        set_d1();
        adj = 16'h8421;
        push_d1_diag();
        mac_ready = 1'b1;
        tick();
        mac_ready = 1'b0;
        tick();
        chk("ovr_node0_valid", out_valid, 1);
        set_all(4095);
        adj = 16'hFFFF;
        mac_ready = 1'b1;
        tick();
        chk("ovr_flag_set", overrun, 1);
        mac_ready = 1'b0;
        wait_done(dk);
        chk("ovr_done_reached", (dk >= 0), 1);
        chk("ovr_flag_sticky", overrun, 1);
        tick(); tick();

        // Reset during node 2 EMIT.
        set_d1();
        adj = 16'h8421;
        push_d1_diag();
        mac_ready = 1'b1;
        tick();
        mac_ready = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid && out_node == 2'd2) begin
                out_ready = 1'b0;
                found = 1;
                break;
            end
        end
        chk("rst_reach_node2", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_node", out_node, 0);
        chk("midrst_outs", {out0, out1, out2, out3}, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_pending", exp_q.size(), 2);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_idle", busy, 0);

        // Normal frame after reset.
        set_d1();
        adj = 16'h000B;
        push_d1_b();
        run_frame(1'b0, vk, dk);
        chk("postrst_done_latency", dk, 8);

        // Capture event during the done cycle is dropped and flagged.
        mac_ready = 1'b1;
        tick();
        chk("donecyc_overrun", overrun, 1);
        chk("donecyc_not_busy", busy, 0);
        mac_ready = 1'b0;
        repeat (3) tick();
        chk("donecyc_no_frame", {busy, out_valid}, 0);

        repeat (2) tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
